// File: rtl/rom_cache_pkg.sv
// rom_cache_pkg: shared FSM state, width helper and lane select for the ROM fetch cache
package rom_cache_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} fill_state_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] lane_sel(input logic [31:0] w, input logic [1:0] sub, input int dw);
        logic [31:0] m;
        m = dw >= 32 ? 32'hFFFF_FFFF : (32'd1 << dw) - 32'd1;
        return (w >> (int'(sub) * dw)) & m;
    endfunction

endpackage

// File: rtl/rom_cache_store.sv
// rom_cache_store: direct-mapped line array with async read, sync write and sync clear-all
module rom_cache_store
    import rom_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TW = 8,
    localparam int IW = clog2(LINES)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag  [LINES];
    logic [31:0]      data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk) begin
        if (clear)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    // tag/data need no reset: a line is only ever read through its valid bit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag[wr_idx]  <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/rom_fetch_cache.sv
// rom_fetch_cache: per-client ROM read stage with a direct-mapped word cache in front of rom_controller
module rom_fetch_cache
    import rom_cache_pkg::*;
#(
    parameter int          ROM_ADDR_WIDTH = 16,
    parameter int          ROM_DATA_WIDTH = 16,
    parameter logic [23:0] ROM_OFFSET = 24'h000000,
    parameter int          LINES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cs,
    input  logic                      oe,
    input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    output logic [ROM_DATA_WIDTH-1:0] rom_data,
    output logic                      rom_valid,
    input  logic                      flush,
    output logic [22:0]               ctrl_addr,
    output logic                      ctrl_req,
    input  logic                      ctrl_ack,
    input  logic                      ctrl_valid,
    input  logic [31:0]               ctrl_data,
    output logic                      ctrl_hit
);

    localparam int S  = clog2(32 / ROM_DATA_WIDTH);
    localparam int SW = S == 0 ? 1 : S;
    localparam int WW = ROM_ADDR_WIDTH - S;
    localparam int IW = clog2(LINES);
    localparam int TW = WW > IW ? WW - IW : 1;

    fill_state_e   state, state_d;
    logic [WW-1:0] word, fill_word;
    logic [SW-1:0] sub, fill_sub;
    logic [TW-1:0] tag, line_tag;
    logic [31:0]   line_data, line_lane, fill_lane;
    logic          line_valid, capture, fill_done, deliver, flushed, wr_en;

    assign word = WW'(rom_addr >> S);
    assign sub  = S == 0 ? '0 : SW'(rom_addr);
    assign tag  = TW'(word >> IW);

    rom_cache_store #(.LINES(LINES), .TW(TW)) u_store (
        .clk     (clk),
        .clear   (!reset || flush),
        .rd_idx  (word[IW-1:0]),
        .rd_valid(line_valid),
        .rd_tag  (line_tag),
        .rd_data (line_data),
        .wr_en   (wr_en),
        .wr_idx  (fill_word[IW-1:0]),
        .wr_tag  (TW'(fill_word >> IW)),
        .wr_data (ctrl_data)
    );

    assign ctrl_hit  = cs && oe && line_valid && line_tag == tag && !flush;
    assign ctrl_addr = 23'(ROM_OFFSET[23:2]) + 23'(fill_word);

    always_comb begin
        state_d   = state;
        ctrl_req  = 1'b0;
        capture   = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                capture = cs && oe && !ctrl_hit && !flush;
                state_d = capture ? REQ : IDLE;
            end
            REQ: begin
                ctrl_req  = 1'b1;
                fill_done = ctrl_ack && ctrl_valid;
                state_d   = !ctrl_ack ? REQ : ctrl_valid ? IDLE : WAIT;
            end
            WAIT: begin
                fill_done = ctrl_valid;
                state_d   = ctrl_valid ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // a flush seen at any point during the fill makes the returning word stale
    assign wr_en   = fill_done && !flush && !flushed && reset;
    assign deliver = fill_done && cs && oe && word == fill_word && sub == fill_sub;

    assign line_lane = lane_sel(line_data, 2'(sub), ROM_DATA_WIDTH);
    assign fill_lane = lane_sel(ctrl_data, 2'(sub), ROM_DATA_WIDTH);
    assign rom_valid = ctrl_hit || deliver;
    assign rom_data  = ctrl_hit ? line_lane[ROM_DATA_WIDTH-1:0] :
                       deliver  ? fill_lane[ROM_DATA_WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            fill_word <= '0;
            fill_sub  <= '0;
            flushed   <= 1'b0;
        end else begin
            state   <= state_d;
            flushed <= state_d == IDLE ? 1'b0 : flushed || flush;
            if (capture) begin
                fill_word <= word;
                fill_sub  <= sub;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_cache.sv
// tb_rom_fetch_cache: scoreboard bench for a 16-bit and an 8-bit rom_fetch_cache instance
module tb_rom_fetch_cache;

    logic        clk = 1'b0, reset = 1'b0, flush = 1'b0;
    logic [1:0]  cs = '0, oe = '0, ack = '0, cv = '0;
    logic [1:0]  rv, req, hit;
    logic [15:0] addr [2];
    logic [31:0] cdata [2];
    logic [22:0] caddr [2];
    logic [15:0] rdata [2];
    logic [15:0] rd16;
    logic [7:0]  rd8;
    int          n_chk = 0, n_fail = 0;

    logic [15:0] exp_q [2][$];
    logic [22:0] req_q [2][$];

    always #5 clk = ~clk;

    rom_fetch_cache #(.ROM_ADDR_WIDTH(16), .ROM_DATA_WIDTH(16), .ROM_OFFSET(24'h010000), .LINES(16)) u16 (
        .clk(clk), .reset(reset), .cs(cs[0]), .oe(oe[0]), .rom_addr(addr[0]), .rom_data(rd16),
        .rom_valid(rv[0]), .flush(flush), .ctrl_addr(caddr[0]), .ctrl_req(req[0]), .ctrl_ack(ack[0]),
        .ctrl_valid(cv[0]), .ctrl_data(cdata[0]), .ctrl_hit(hit[0])
    );

    rom_fetch_cache #(.ROM_ADDR_WIDTH(16), .ROM_DATA_WIDTH(8), .ROM_OFFSET(24'h000000), .LINES(4)) u8 (
        .clk(clk), .reset(reset), .cs(cs[1]), .oe(oe[1]), .rom_addr(addr[1]), .rom_data(rd8),
        .rom_valid(rv[1]), .flush(flush), .ctrl_addr(caddr[1]), .ctrl_req(req[1]), .ctrl_ack(ack[1]),
        .ctrl_valid(cv[1]), .ctrl_data(cdata[1]), .ctrl_hit(hit[1])
    );

    assign rdata[0] = rd16;
    assign rdata[1] = {8'h00, rd8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // monitor: every delivered word and every accepted request is matched against the scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rv[d]) begin
                if (exp_q[d].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid[%0d]: got data %0h expected no rom_valid", d, rdata[d]);
                end else
                    chk($sformatf("rom_data[%0d]", d), 32'(rdata[d]), 32'(exp_q[d].pop_front()));
            end else
                chk($sformatf("idle_data[%0d]", d), 32'(rdata[d]), 32'h0);
            if (req[d] && ack[d]) begin
                if (req_q[d].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req[%0d]: got addr %0h expected no request", d, caddr[d]);
                end else
                    chk($sformatf("ctrl_addr[%0d]", d), 32'(caddr[d]), 32'(req_q[d].pop_front()));
            end
        end
    end

    task automatic miss_fill(input int d, input logic [15:0] a, input logic [22:0] ea,
                             input logic [31:0] w, input logic [15:0] ed, input bit both);
        cs[d] = 1'b1; oe[d] = 1'b1; addr[d] = a;
        req_q[d].push_back(ea);
        #2;
        chk("miss_hit", 32'(hit[d]), 32'h0);
        chk("miss_req_early", 32'(req[d]), 32'h0);
        tick;
        chk("req_latency", 32'(req[d]), 32'h1);
        ack[d] = 1'b1;
        exp_q[d].push_back(ed);
        if (both) begin
            cv[d] = 1'b1; cdata[d] = w;
        end
        tick;
        ack[d] = 1'b0;
        if (!both) begin
            chk("req_after_ack", 32'(req[d]), 32'h0);
            cv[d] = 1'b1; cdata[d] = w;
            tick;
        end
        cv[d] = 1'b0; cs[d] = 1'b0; oe[d] = 1'b0;
        chk("req_back_idle", 32'(req[d]), 32'h0);
    endtask

    task automatic hit_read(input int d, input logic [15:0] a, input logic [15:0] ed);
        exp_q[d].push_back(ed);
        cs[d] = 1'b1; oe[d] = 1'b1; addr[d] = a;
        #2;
        chk("hit", 32'(hit[d]), 32'h1);
        tick;
        chk("hit_no_req", 32'(req[d]), 32'h0);
        cs[d] = 1'b0; oe[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        addr[0] = '0; addr[1] = '0; cdata[0] = '0; cdata[1] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_valid", 32'(rv[0]), 32'h0);
        chk("rst_hit", 32'(hit[0]), 32'h0);
        chk("rst_req", 32'(req[0]), 32'h0);
        chk("rst_addr16", 32'(caddr[0]), 32'h004000);
        chk("rst_addr8", 32'(caddr[1]), 32'h0);

        // basic miss then same-cycle hit on the other half-word
        miss_fill(0, 16'h0003, 23'h004001, 32'hAABBCCDD, 16'hAABB, 1'b0);
        hit_read(0, 16'h0002, 16'hCCDD);

        // 8-bit client, 4 lines: word 4 evicts word 0
        miss_fill(1, 16'h0001, 23'h0, 32'h11223344, 16'h0033, 1'b0);
        hit_read(1, 16'h0003, 16'h0011);
        miss_fill(1, 16'h0012, 23'h4, 32'h55667788, 16'h0066, 1'b0);
        miss_fill(1, 16'h0000, 23'h0, 32'h11223344, 16'h0044, 1'b1);
        hit_read(1, 16'h0002, 16'h0022);

        // client moves during WAIT: word cached, no delivery, new address hits in IDLE
        cs[0] = 1'b1; oe[0] = 1'b1; addr[0] = 16'h0010;
        req_q[0].push_back(23'h004008);
        tick;
        chk("chg_req", 32'(req[0]), 32'h1);
        ack[0] = 1'b1;
        tick;
        ack[0] = 1'b0; addr[0] = 16'h0011; cv[0] = 1'b1; cdata[0] = 32'h12345678;
        tick;
        cv[0] = 1'b0;
        exp_q[0].push_back(16'h1234);
        #2;
        chk("chg_hit", 32'(hit[0]), 32'h1);
        tick;
        chk("chg_no_req", 32'(req[0]), 32'h0);
        cs[0] = 1'b0; oe[0] = 1'b0;

        // flush during WAIT: fill dropped, all lines invalid
        cs[0] = 1'b1; oe[0] = 1'b1; addr[0] = 16'h0020;
        req_q[0].push_back(23'h004010);
        tick;
        ack[0] = 1'b1;
        tick;
        ack[0] = 1'b0; flush = 1'b1; cs[0] = 1'b0; oe[0] = 1'b0;
        tick;
        flush = 1'b0; cv[0] = 1'b1; cdata[0] = 32'hDEADBEEF;
        tick;
        cv[0] = 1'b0;
        miss_fill(0, 16'h0020, 23'h004010, 32'hCAFEF00D, 16'hF00D, 1'b0);
        miss_fill(0, 16'h0002, 23'h004001, 32'hAABBCCDD, 16'hCCDD, 1'b0);

        // reset during WAIT: fill abandoned, stray ctrl_valid ignored
        cs[0] = 1'b1; oe[0] = 1'b1; addr[0] = 16'h0004;
        req_q[0].push_back(23'h004002);
        tick;
        ack[0] = 1'b1;
        tick;
        ack[0] = 1'b0; reset = 1'b0; cs[0] = 1'b0; oe[0] = 1'b0;
        tick;
        reset = 1'b1;
        chk("rstw_req", 32'(req[0]), 32'h0);
        chk("rstw_addr", 32'(caddr[0]), 32'h004000);
        cv[0] = 1'b1; cdata[0] = 32'h77778888;
        tick;
        cv[0] = 1'b0;
        chk("rstw_idle", 32'(req[0]), 32'h0);
        miss_fill(0, 16'h0004, 23'h004002, 32'h5555AAAA, 16'hAAAA, 1'b0);
        miss_fill(0, 16'h0000, 23'h004000, 32'h13572468, 16'h2468, 1'b0);

        repeat (3) tick;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("exp_left[%0d]", d), 32'(exp_q[d].size()), 32'h0);
            chk($sformatf("req_left[%0d]", d), 32'(req_q[d].size()), 32'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_fetch_cache.md
Name: rom_fetch_cache

Overview:
- Per-client read stage directly upstream of rom_controller; one instance per ROM port (program, tile, sprite, sound).
- Translates a client ROM address into a 32-bit SDRAM word address at a fixed segment offset.
- Holds recently fetched words in a small direct-mapped cache. Hits return in the same cycle; misses run the req/ack/valid handshake toward the controller.

Parameters:
- ROM_ADDR_WIDTH, 16, width of rom_addr, in units of ROM_DATA_WIDTH.
- ROM_DATA_WIDTH, 16, client data width; legal values 8, 16, 32.
- ROM_OFFSET, 24'h000000, segment byte offset in SDRAM; must be 4-byte aligned.
- LINES, 16, cache lines of one 32-bit word each; power of two, 2..64.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- cs  in  1  client chip select.
- oe  in  1  client read enable.
- rom_addr  in  ROM_ADDR_WIDTH  client address.
- rom_data  out  ROM_DATA_WIDTH  read data.
- rom_valid  out  1  rom_data valid for the current rom_addr.
- flush  in  1  invalidate all lines (driven by ioctl_download).
- ctrl_addr  out  23  SDRAM 32-bit word address.
- ctrl_req  out  1  fetch request.
- ctrl_ack  in  1  controller accepted the request.
- ctrl_valid  in  1  ctrl_data carries the fetched word.
- ctrl_data  in  32  SDRAM read word.
- ctrl_hit  out  1  current access hits the cache.

Behaviour:
- Address math:
  - S = log2(32/ROM_DATA_WIDTH).
  - word = rom_addr >> S; sub = rom_addr[S-1:0].
  - ctrl_addr = ROM_OFFSET[23:2] + word, zero-extended to 23 bits; wraps mod 2^23.
- Lane select: little-endian; sub=0 selects ctrl_data/line bits [DW-1:0].
- Cache organisation:
  - index = word[log2(LINES)-1:0]; tag = remaining word bits.
  - Per-line valid bit, tag and data, all held in flops.
- Lookup and hit:
  - Lookup is combinational.
  - ctrl_hit = cs & oe & valid[index] & (tag match) & !flush.
  - On a hit: rom_valid=1 and rom_data = lane of the line, in the same cycle (0 latency).
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if cs&oe&!ctrl_hit&!flush, capture word/sub into fill registers and go to REQ next cycle.
  - REQ: ctrl_req=1 and ctrl_addr from the fill registers. On ctrl_ack=1, go to WAIT. If ctrl_ack and ctrl_valid arrive in the same cycle, treat as WAIT completion and go to IDLE.
  - WAIT: ctrl_req=0. On ctrl_valid=1, write the line (valid=1, tag, data) and go to IDLE.
- Miss latency: ctrl_req rises 1 cycle after a miss is seen. The fill cycle drives rom_valid=1 and rom_data = lane of ctrl_data, but only if cs&oe are still high and rom_addr equals the captured address. Otherwise the word is only written to the cache.
- ctrl_valid outside the REQ/WAIT fill-completion path is ignored.
- Client changes during a fill:
  - cs drop or address change during REQ/WAIT does not cancel the fill, since the controller cannot abort.
  - The new address is looked up again after returning to IDLE.
- rom_valid and rom_data are 0 when not hit and not in a fill delivery cycle.
- flush:
  - Clears all valid bits at the next edge.
  - A fill completing in the same cycle as flush, or while a flush occurred during that fill, is not written. A sticky flag tracks this; it is cleared on entering IDLE.
  - flush does not abort REQ/WAIT.
- Reset (reset==0 at an edge):
  - state=IDLE, ctrl_req=0, all valid bits=0, fill registers=0, flag=0.
  - Outputs are then: rom_valid=0, ctrl_hit=0, ctrl_addr=ROM_OFFSET[23:2].
  - Reset mid-fill abandons the fill; a later ctrl_valid is ignored in IDLE.
- Only one outstanding request at a time. ctrl_req stays high until acked.

Decomposition:
- Shared package rom_cache_pkg:
  - FSM state enum (IDLE/REQ/WAIT).
  - clog2-style width function.
  - lane-select function (32-bit word, sub, width -> lane).
- One sub-module, rom_cache_store: LINES x (valid, tag, data) flop array.
  - Async read port; sync write port.
  - Synchronous clear-all, used by reset and flush.

Test Plan:
- DW=16, OFFSET=24'h010000, empty cache; read rom_addr=0x0003 -> ctrl_addr=0x004001, ctrl_req 1 cycle after the miss. Ack, then valid with ctrl_data=0xAABBCCDD -> rom_valid, rom_data=0xAABB. Re-read 0x0002 -> same-cycle hit, rom_data=0xCCDD, no ctrl_req.
- DW=8, LINES=4; fill word 0 then word 4, which conflicts on index 0 -> second fill evicts the first; re-read word 0 misses again and re-issues the request.
- ctrl_ack and ctrl_valid high in the same REQ cycle -> line written, FSM returns to IDLE, exactly one request issued.
- Client changes rom_addr during WAIT -> fill word cached but rom_valid=0 in the fill cycle; new address looked up in IDLE.
- flush during WAIT -> completing fill not written; all lines invalid afterwards; next read misses.
- reset=0 during WAIT -> ctrl_req=0, IDLE, valid bits cleared; stray ctrl_valid next cycle -> no rom_valid, no cache write.
